inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 Parameter TIMEOUT, default 16, meaning maximum cycles to wait for imem_ack before a fetch error.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_ack  input  1  memory returns data this cycle.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-009 redirect  input  1  PC redirect (taken branch or jump) from the controller's PCSrc.
REQ-010 redirect_pc  input  32  redirect target address.
REQ-011 instr_valid  output  1  instr, instr_pc and the decoded fields hold a fetched instruction.
REQ-012 instr_ready  input  1  downstream consumes the instruction when instr_valid=1.
REQ-013 instr  output  32  registered instruction word.
REQ-014 instr_pc  output  32  address of instr.
REQ-015 op  output  7  instr[6:0]; funct3 output 3, instr[14:12]; funct7b5 output 1, instr[30].
REQ-016 fetch_err  output  1  sticky error flag: timeout or misaligned redirect.
REQ-017 fetch_count  output  32  count of consumed instructions.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, VALID and ERR.
REQ-019 IDLE SHALL move to REQ unconditionally one cycle after reset release.
REQ-020 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-021 In every other state, imem_req SHALL be 0.
REQ-022 In REQ with imem_ack=1 and redirect=0, the block SHALL set instr<=imem_rdata, instr_pc<=pc, pc<=pc+4 (mod 2^32 wrap) and move to VALID.
REQ-023 instr_valid SHALL be 1 exactly in VALID, which gives one cycle of latency from ack to valid.
REQ-024 In VALID with instr_ready=1, the block SHALL increment fetch_count (wrapping at 2^32) and move to REQ; with instr_ready=0, it SHALL hold instr, instr_pc and the fields stable.
REQ-025 A wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-026 If the wait counter reaches TIMEOUT, the block SHALL move to ERR and set fetch_err.
REQ-027 redirect=1 in IDLE, REQ or VALID SHALL set pc<=redirect_pc and move to REQ, with the wait counter cleared.
REQ-028 redirect SHALL take priority over imem_ack in the same cycle: imem_rdata is discarded and instr is not updated.
REQ-029 redirect together with instr_valid=1 and instr_ready=1 SHALL count as a completed handshake (fetch_count increments) and the redirect SHALL also apply.
REQ-030 redirect with instr_valid=1 and instr_ready=0 SHALL drop the held instruction uncounted, and instr_valid SHALL be 0 on the next cycle.
REQ-031 redirect with redirect_pc[1:0]!=0 SHALL move the block to ERR and set fetch_err, and pc SHALL be unchanged.
REQ-032 ERR SHALL be absorbing: only rst_n exits it, redirect and ack are ignored, and imem_req=0 and instr_valid=0.
REQ-033 op, funct3 and funct7b5 SHALL be combinational slices of the instr register.

Reset
REQ-034 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_pc=0, fetch_count=0, fetch_err=0, wait counter=0, imem_req=0 and instr_valid=0.
REQ-035 Reset asserted mid-request or mid-hold SHALL abandon the transaction with no partial update after release.

Verification
REQ-036 Reset release, imem_ack one cycle after each req with rdata=0x00500093, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8; instr_valid 1 cycle after each ack; op=0x13, funct3=0; fetch_count=3 after three handshakes.
REQ-037 instr_ready held 0 for 5 cycles in VALID -> instr/instr_pc stable, imem_req=0, fetch_count unchanged; ready=1 -> next req at pc+4.
REQ-038 redirect=1, redirect_pc=0x100 in the same cycle as imem_ack -> data discarded, next imem_addr=0x100, fetch_count unchanged.
REQ-039 No ack for 16 cycles -> fetch_err=1 and permanent ERR (redirect ignored) until rst_n pulse, then fetch restarts at RESET_PC.
REQ-040 redirect_pc=0x102 -> fetch_err=1, no further imem_req.
REQ-041 pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000; rst_n pulsed while in REQ -> outputs at reset values immediately.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues word fetches to instruction memory, holds one
// fetched instruction for a ready/valid consumer, and follows PC redirects.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic        fetch_err,
  output logic [31:0] fetch_count
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         instr_pc_q, instr_pc_d;
  logic [31:0]         count_q, count_d;
  logic                err_q, err_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                redir_bad;

  assign redir_bad = redirect && (redirect_pc[1:0] != 2'b00);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      instr_pc_q <= 32'h0;
      count_q    <= 32'h0;
      err_q      <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      count_q    <= count_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    count_d    = count_q;
    err_d      = err_q;
    wait_d     = wait_q;

    // A handshake in VALID completes even when a redirect arrives alongside it
    if (state_q == VALID && instr_ready)
      count_d = count_q + 32'd1;

    if (state_q != ERR && redirect) begin
      if (redir_bad) begin
        state_d = ERR;
        err_d   = 1'b1;
      end else begin
        state_d = REQ;
        pc_d    = redirect_pc;
        wait_d  = '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = REQ;
          wait_d  = '0;
        end
        REQ: begin
          if (imem_ack) begin
            state_d    = VALID;
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
          end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
            state_d = ERR;
            err_d   = 1'b1;
            wait_d  = wait_q + 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        VALID: begin
          if (instr_ready) begin
            state_d = REQ;
            wait_d  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == VALID);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign op          = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7b5    = instr_q[30];
  assign fetch_err   = err_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed-vector bench for inst_fetch with hand-computed expectations.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        fetch_err;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  inst_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .fetch_err(fetch_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(imem_req),    32'd0);
    chk({tag, "_vld"},   32'(instr_valid), 32'd0);
    chk({tag, "_addr"},  imem_addr,        32'h0);
    chk({tag, "_instr"}, instr,            32'h0000_0013);
    chk({tag, "_ipc"},   instr_pc,         32'h0);
    chk({tag, "_cnt"},   fetch_count,      32'd0);
    chk({tag, "_err"},   32'(fetch_err),   32'd0);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    tick();
    chk("first_req", 32'(imem_req), 32'd1);

    // Three sequential fetches with ack one cycle after each request
    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", imem_addr, 32'(4 * i));
      tick();
      chk("seq_req_wait", 32'(imem_req), 32'd1);
      imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
      tick();
      imem_ack = 1'b0;
      chk("seq_vld", 32'(instr_valid), 32'd1);
      chk("seq_req_off", 32'(imem_req), 32'd0);
      chk("seq_instr", instr, 32'h0050_0093);
      chk("seq_ipc", instr_pc, 32'(4 * i));
      chk("seq_op", 32'(op), 32'h13);
      chk("seq_f3", 32'(funct3), 32'd0);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("seq_cnt", fetch_count, 32'(i + 1));
    end
    chk("seq_cnt3", fetch_count, 32'd3);

    // Backpressure: hold for five cycles
    imem_ack = 1'b1; imem_rdata = 32'h4020_8233;
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_vld", 32'(instr_valid), 32'd1);
      chk("hold_instr", instr, 32'h4020_8233);
      chk("hold_ipc", instr_pc, 32'h0000_000C);
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_cnt", fetch_count, 32'd3);
      tick();
    end
    chk("hold_op", 32'(op), 32'h33);
    chk("hold_f7b5", 32'(funct7b5), 32'd1);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("rel_cnt", fetch_count, 32'd4);
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'h0000_0010);

    // Redirect coincident with ack discards the data
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    imem_ack = 1'b0; redirect = 1'b0;
    chk("rda_addr", imem_addr, 32'h100);
    chk("rda_req", 32'(imem_req), 32'd1);
    chk("rda_vld", 32'(instr_valid), 32'd0);
    chk("rda_instr", instr, 32'h4020_8233);
    chk("rda_cnt", fetch_count, 32'd4);
    imem_ack = 1'b1; imem_rdata = 32'h0020_C1B3;
    tick();
    imem_ack = 1'b0;
    chk("rda_ipc", instr_pc, 32'h100);
    chk("rda_f3", 32'(funct3), 32'd4);
    chk("rda_f7b5", 32'(funct7b5), 32'd0);

    // Redirect while holding, not ready: instruction dropped uncounted
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    chk("drop_vld", 32'(instr_valid), 32'd0);
    chk("drop_cnt", fetch_count, 32'd4);
    chk("drop_addr", imem_addr, 32'h200);

    // Redirect together with a completed handshake
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_ack = 1'b0;
    chk("hs_ipc", instr_pc, 32'h200);
    redirect = 1'b1; redirect_pc = 32'h300; instr_ready = 1'b1;
    tick();
    redirect = 1'b0; instr_ready = 1'b0;
    chk("hs_cnt", fetch_count, 32'd5);
    chk("hs_addr", imem_addr, 32'h300);
    chk("hs_req", 32'(imem_req), 32'd1);

    // PC wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("wrap_addr1", imem_addr, 32'h0);
    chk("wrap_cnt", fetch_count, 32'd6);
    chk("wrap_req", 32'(imem_req), 32'd1);

    // Reset mid-request takes effect immediately
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    #1;
    rst_n = 1'b1;
    tick();
    chk("rst_mid_req", 32'(imem_req), 32'd1);
    chk("rst_mid_addr", imem_addr, 32'h0);

    // Timeout: sixteen request cycles without ack
    for (int i = 0; i < 15; i++) tick();
    chk("to_req15", 32'(imem_req), 32'd1);
    chk("to_err15", 32'(fetch_err), 32'd0);
    tick();
    chk("to_err", 32'(fetch_err), 32'd1);
    chk("to_req", 32'(imem_req), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h40; imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("err_abs_req", 32'(imem_req), 32'd0);
      chk("err_abs_vld", 32'(instr_valid), 32'd0);
      chk("err_abs_err", 32'(fetch_err), 32'd1);
    end
    redirect = 1'b0; imem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_err");
    #1;
    rst_n = 1'b1;
    tick();
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, 32'h0);

    // Misaligned redirect
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    chk("mis_err", 32'(fetch_err), 32'd1);
    chk("mis_req", 32'(imem_req), 32'd0);
    chk("mis_pc", imem_addr, 32'h0);
    tick();
    tick();
    chk("mis_req_late", 32'(imem_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
